// File: rtl/mac_row_dual.sv
// mac_row_dual: one row of a systolic MAC array with a runtime-selectable
// dataflow. Weight-stationary (WS) keeps a kernel value per column and adds
// its product to the psum arriving from the north. Output-stationary (OS)
// keeps an accumulator per column, takes weights from the north and drains
// results on flush. Activations and instructions move one column east per cycle.
module mac_row_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          in_w,
  input  logic [2:0]             inst_w,   // {flush, execute, load}
  input  logic                   mode,     // 0 = WS, 1 = OS
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic                   busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t               state;
  logic                 mode_q;

  logic [bw-1:0]        a_q      [col];
  logic [2:0]           inst_q   [col];
  logic [bw-1:0]        w_q      [col];
  logic [col-1:0]       w_loaded;
  logic [psum_bw-1:0]   acc      [col];
  logic [psum_bw-1:0]   out_q    [col];
  logic [col-1:0]       valid_q;

  logic [bw-1:0]        a_in     [col];
  logic [2:0]           inst_in  [col];
  logic [psum_bw-1:0]   psum_in  [col];
  logic [psum_bw-1:0]   p_ws     [col];
  logic [psum_bw-1:0]   p_os     [col];
  logic [col-1:0]       cap;
  logic [col-1:0]       commit;
  logic                 chain;
  logic                 busy_c;

  // Unsigned activation times signed weight, sign-extended (or wrapped) to psum_bw.
  function automatic logic [psum_bw-1:0] mul_sx(input logic [bw-1:0] a,
                                                input logic [bw-1:0] w);
    logic signed [2*bw:0] a_x;
    logic signed [2*bw:0] w_x;
    logic signed [2*bw:0] prod;
    a_x  = $signed({{bw{1'b0}}, 1'b0, a});
    w_x  = $signed({{(bw+1){w[bw-1]}}, w});
    prod = a_x * w_x;
    return psum_bw'(prod);
  endfunction

  // Per-column operands: column 0 takes the row inputs, the rest take the
  // registered token of their western neighbour.
  always_comb begin
    a_in[0]    = in_w;
    inst_in[0] = inst_w;
    for (int i = 1; i < col; i++) begin
      a_in[i]    = a_q[i-1];
      inst_in[i] = inst_q[i-1];
    end
    for (int i = 0; i < col; i++) begin
      psum_in[i] = in_n[i*psum_bw +: psum_bw];
      p_ws[i]    = mul_sx(a_in[i], w_q[i]);
      p_os[i]    = mul_sx(a_in[i], psum_in[i][bw-1:0]);
      cap[i]     = !mode_q && inst_in[i][0] && !w_loaded[i];
    end
  end

  // Kernel commit: unloaded columns keep overwriting w_q with each load they
  // see; the kernel locks in the cycle the burst head reaches the last column,
  // which leaves the k-th value fed in column col-1-k (feed last column first).
  always_comb begin
    chain = 1'b1;
    for (int i = col - 1; i >= 0; i--) begin
      commit[i] = cap[i] & chain;
      chain     = commit[i];
    end
  end

  // Row activity: any instruction bit entering or still rippling east.
  always_comb begin
    busy_c = |inst_w;
    for (int i = 0; i < col; i++) begin
      busy_c = busy_c | (|inst_q[i]);
    end
  end

  assign busy = busy_c & ~reset;

  // Mode FSM: mode is sampled only while nothing is in flight so every token
  // of a burst is processed under the same dataflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_w != 3'b000) state <= ACTIVE;
          else                  mode_q <= mode;
        end
        ACTIVE: begin
          if (!busy) begin
            state  <= IDLE;
            mode_q <= mode;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Column datapath: token ripple, WS kernel/psum update, OS accumulate/drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        a_q[i]    <= '0;
        inst_q[i] <= '0;
        w_q[i]    <= '0;
        acc[i]    <= '0;
        out_q[i]  <= '0;
      end
      w_loaded <= '0;
      valid_q  <= '0;
    end else begin
      for (int i = 0; i < col; i++) begin
        a_q[i]     <= a_in[i];
        inst_q[i]  <= inst_in[i];
        valid_q[i] <= 1'b0;
        if (!mode_q) begin
          if (cap[i])         w_q[i]      <= a_in[i];
          if (commit[i])      w_loaded[i] <= 1'b1;
          if (inst_in[i][2])  w_loaded[i] <= 1'b0;
          if (inst_in[i][1]) begin
            // Uses the w_q held before any same-cycle load.
            out_q[i]   <= psum_in[i] + p_ws[i];
            valid_q[i] <= 1'b1;
          end
        end else begin
          if (inst_in[i][2]) begin
            out_q[i]   <= acc[i] + (inst_in[i][1] ? p_os[i] : '0);
            acc[i]     <= '0;
            valid_q[i] <= 1'b1;
          end else if (inst_in[i][1]) begin
            acc[i] <= acc[i] + p_os[i];
          end
        end
      end
    end
  end

  // Flatten per-column results onto the south bus.
  always_comb begin
    for (int i = 0; i < col; i++) begin
      out_s[i*psum_bw +: psum_bw] = out_q[i];
    end
  end

  assign valid = valid_q;

endmodule

// File: tb/tb_mac_row_dual.sv
// Bench for mac_row_dual: directed scenarios plus randomized traffic, all
// compared against a token-timing reference model and directed constants.
module tb_mac_row_dual;

  localparam int BW  = 4;
  localparam int PW  = 16;
  localparam int COL = 8;
  localparam int VW  = PW * COL;
  localparam int W   = COL + VW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [BW-1:0]    in_w;
  logic [2:0]       inst_w;
  logic             mode;
  logic [VW-1:0]    in_n;
  logic [VW-1:0]    out_s;
  logic [COL-1:0]   valid;
  logic             busy;

  logic [BW-1:0]    in_w8;
  logic [2:0]       inst8;
  logic             mode8;
  logic [15:0]      in_n8;
  logic [15:0]      out8;
  logic [1:0]       valid8;
  logic             busy8;

  mac_row_dual #(.bw(BW), .psum_bw(PW), .col(COL)) dut (
    .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .mode(mode),
    .in_n(in_n), .out_s(out_s), .valid(valid), .busy(busy)
  );

  mac_row_dual #(.bw(4), .psum_bw(8), .col(2)) dut8 (
    .clk(clk), .reset(reset), .in_w(in_w8), .inst_w(inst8), .mode(mode8),
    .in_n(in_n8), .out_s(out8), .valid(valid8), .busy(busy8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A token entering at cycle t is handled by column i at cycle t+i; the
  // queues hold the tokens of the last COL cycles (index 0 = previous cycle).
  logic [2:0]    past_i[$];
  logic [BW-1:0] past_a[$];
  logic [BW-1:0] m_w[COL];
  bit            m_loaded[COL];
  logic [PW-1:0] m_acc[COL];
  logic [PW-1:0] m_out[COL];
  logic [COL-1:0] m_valid;
  logic          m_mode_q;
  bit            m_busy;

  function automatic int sval(input logic [BW-1:0] w);
    return w[BW-1] ? int'(w) - (1 << BW) : int'(w);
  endfunction

  function automatic logic [PW-1:0] slice(input logic [VW-1:0] v, input int i);
    return v[i*PW +: PW];
  endfunction

  function automatic logic [VW-1:0] splat(input logic [PW-1:0] x);
    logic [VW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*PW +: PW] = x;
    return v;
  endfunction

  function automatic logic [VW-1:0] randvec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    past_i.delete();
    past_a.delete();
    for (int i = 0; i < COL; i++) begin
      past_i.push_back(3'b000);
      past_a.push_back('0);
      m_w[i] = '0; m_loaded[i] = 0; m_acc[i] = '0; m_out[i] = '0;
    end
    m_valid  = '0;
    m_mode_q = 1'b0;
    m_busy   = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [2:0]    ti[COL];
    logic [BW-1:0] ta[COL];
    bit            com[COL];
    bit            head;
    int            prod;
    logic [PW-1:0] nin;
    logic [VW-1:0] ov;
    m_busy = (inst_w != 3'b000);
    for (int i = 0; i < COL; i++) if (past_i[i] != 3'b000) m_busy = 1;
    ti[0] = inst_w; ta[0] = in_w;
    for (int i = 1; i < COL; i++) begin ti[i] = past_i[i-1]; ta[i] = past_a[i-1]; end
    // Kernel locks when a load burst's first value reaches the last column.
    head = 1;
    for (int i = COL - 1; i >= 0; i--) begin
      com[i] = head && !m_mode_q && ti[i][0] && !m_loaded[i];
      head   = com[i];
    end
    for (int i = 0; i < COL; i++) begin
      m_valid[i] = 1'b0;
      nin = slice(in_n, i);
      if (!m_mode_q) begin
        prod = int'(ta[i]) * sval(m_w[i]);
        if (ti[i][1]) begin m_out[i] = nin + PW'(prod); m_valid[i] = 1'b1; end
        if (ti[i][0] && !m_loaded[i]) m_w[i] = ta[i];
        if (com[i]) m_loaded[i] = 1;
        if (ti[i][2]) m_loaded[i] = 0;
      end else begin
        prod = int'(ta[i]) * sval(nin[BW-1:0]);
        if (ti[i][2]) begin
          m_out[i]   = m_acc[i] + (ti[i][1] ? PW'(prod) : PW'(0));
          m_acc[i]   = '0;
          m_valid[i] = 1'b1;
        end else if (ti[i][1]) begin
          m_acc[i] = m_acc[i] + PW'(prod);
        end
      end
    end
    if (!m_busy) m_mode_q = mode;
    for (int i = 0; i < COL; i++) ov[i*PW +: PW] = m_out[i];
    exp_q.push_back({m_valid, ov});
    past_i.push_front(inst_w); void'(past_i.pop_back());
    past_a.push_front(in_w);   void'(past_a.pop_back());
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic [2:0] inst, input logic [BW-1:0] a,
                       input logic [VW-1:0] n, input logic md);
    logic [W-1:0] e;
    inst_w = inst; in_w = a; in_n = n; mode = md;
    #1;
    model_step();
    check("busy", busy, m_busy);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("out_s", out_s, e[VW-1:0]);
    check("valid", valid, e[W-1:VW]);
    check("mode_q", dut.mode_q, m_mode_q);
  endtask

  task automatic idle(input int n, input logic md, input logic [VW-1:0] nv);
    for (int k = 0; k < n; k++) cycle(3'b000, '0, nv, md);
  endtask

  // ---------------- stimulus ----------------
  logic [VW-1:0]  nv;
  logic [COL-1:0] ev;
  logic [2:0]     ri;

  initial begin
    reset = 1'b1; in_w = '0; inst_w = '0; mode = 1'b0; in_n = '0;
    in_w8 = '0; inst8 = '0; mode8 = 1'b0; in_n8 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Reset mid-stream, observed without a clock edge.
    idle(1, 1'b0, '0);
    for (int k = 0; k < 3; k++) cycle(3'b010, BW'($urandom), randvec(), 1'b0);
    reset = 1'b1;
    #1;
    check("rst_out_s", out_s, '0);
    check("rst_valid", valid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_mode_q", dut.mode_q, 1'b0);
    @(posedge clk); #1;
    inst_w = '0; reset = 1'b0;
    model_reset();

    // WS kernel load, last column first, then one execute.
    idle(2, 1'b0, '0);
    for (int k = 0; k < COL; k++) cycle(3'b001, BW'(COL - 1 - k), randvec(), 1'b0);
    nv = splat(PW'(5));
    for (int k = 0; k <= COL; k++) begin
      if (k == 0) cycle(3'b010, BW'(3), nv, 1'b0);
      else        cycle(3'b000, '0, nv, 1'b0);
      ev = '0;
      if (k < COL) ev[k] = 1'b1;
      check("ws_valid_timing", valid, ev);
      if (k < COL) check("ws_out", slice(out_s, k), PW'(5 + 3 * k));
    end

    // WS signed weight -8 in column 0.
    cycle(3'b100, '0, '0, 1'b0);
    idle(COL + 1, 1'b0, '0);
    for (int k = 0; k < COL; k++) cycle(3'b001, (k == COL - 1) ? BW'(8) : BW'($urandom), '0, 1'b0);
    cycle(3'b010, BW'(15), '0, 1'b0);
    check("ws_signed", slice(out_s, 0), 16'hFF88);
    idle(COL + 1, 1'b0, '0);

    // Mode change while a WS execute ripples.
    nv = randvec();
    nv[PW-1:0] = PW'(100);
    idle(2, 1'b0, nv);
    cycle(3'b010, BW'(1), nv, 1'b0);
    check("gate_ws_result", slice(out_s, 0), PW'(92));
    for (int k = 1; k <= COL + 2; k++) begin
      cycle(3'b000, '0, nv, 1'b1);
      check("gate_mode_q", dut.mode_q, (k >= COL + 1) ? 1'b1 : 1'b0);
    end

    // OS accumulate 4 x (2*3), then two flushes.
    nv = splat(PW'(3));
    idle(2, 1'b1, nv);
    for (int k = 0; k < 4; k++) cycle(3'b010, BW'(2), nv, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= COL; k++) begin
        if (k == 0) cycle(3'b100, '0, nv, 1'b1);
        else        cycle(3'b000, '0, nv, 1'b1);
        ev = '0;
        if (k < COL) ev[k] = 1'b1;
        check("os_valid_timing", valid, ev);
        if (k < COL) check("os_out", slice(out_s, k), (f == 0) ? PW'(24) : PW'(0));
      end
    end

    // OS flush together with execute: 10 accumulated plus 6.
    nv = splat(PW'(2));
    cycle(3'b010, BW'(5), nv, 1'b1);
    cycle(3'b110, BW'(3), nv, 1'b1);
    check("os_flush_exec", slice(out_s, 0), PW'(16));
    idle(COL + 1, 1'b1, nv);
    cycle(3'b100, '0, nv, 1'b1);
    check("os_acc_cleared", slice(out_s, 0), PW'(0));
    idle(COL + 1, 1'b1, nv);

    // Randomized bursts separated by idle gaps so mode can change.
    for (int c = 0; c < 480; c++) begin
      ri = ((c % 24) < 14) ? 3'($urandom_range(0, 7)) : 3'b000;
      cycle(ri, BW'($urandom), randvec(), 1'($urandom_range(0, 1)));
    end

    // OS wrap on an 8-bit accumulator: 3 x (15*7) = 315 -> 59.
    mode8 = 1'b1;
    @(posedge clk); #1;
    in_n8 = {8'd7, 8'd7};
    for (int k = 0; k < 3; k++) begin
      inst8 = 3'b010; in_w8 = 4'd15;
      @(posedge clk); #1;
    end
    inst8 = 3'b100; in_w8 = '0;
    @(posedge clk); #1;
    check("wrap_out0", out8[7:0], 8'd59);
    check("wrap_valid0", valid8, 2'b01);
    inst8 = 3'b000;
    @(posedge clk); #1;
    check("wrap_out1", out8[15:8], 8'd59);
    check("wrap_valid1", valid8, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
